// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared types and constants for the cache miss/refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  localparam int c_AW_DEFAULT = 16;
  localparam int c_DW_DEFAULT = 16;
  localparam int c_CW_DEFAULT = 16;

  // Address split used by the cache: [15:8] tag, [7:0] index
  localparam int c_TAG_MSB = 15;
  localparam int c_TAG_LSB = 8;
  localparam int c_IDX_MSB = 7;
  localparam int c_IDX_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_FILL   = 3'd3,
    ST_RESP   = 3'd4,
    ST_MEM_WR = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_sat.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at its all-ones value.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CW{1'b1}})) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Miss/refill controller between the CPU memory stage and the
//               2-way cache; write-through stores, load refill from memory.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int AW = c_AW_DEFAULT,
  parameter int DW = c_DW_DEFAULT,
  parameter int CW = c_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_wdata,
  output logic          cache_wcmd,
  input  logic [DW-1:0] cache_rdata,
  input  logic          cache_hit,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_start;
  logic          w_hit_inc;
  logic          w_miss_inc;

  // The completion cycle itself never restarts an access, so a CPU that
  // drops cpu_req on seeing cpu_done is not retriggered.
  assign w_start = cpu_req && !cpu_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = cpu_we ? ST_MEM_WR : ST_LOOKUP;
      ST_LOOKUP: begin
        w_next     = cache_hit ? ST_IDLE : ST_MEM_RD;
        w_hit_inc  = cache_hit;
        w_miss_inc = !cache_hit;
      end
      ST_MEM_RD: if (mem_ack) w_next = ST_FILL;
      ST_FILL:   w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      ST_MEM_WR: if (mem_ack) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_data      <= '0;
      cpu_rdata   <= '0;
      cpu_done    <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      cache_wcmd  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      cache_wcmd <= 1'b0;
      cpu_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr     <= cpu_addr;
            cache_addr <= cpu_addr;
            if (cpu_we) begin
              cache_wdata <= cpu_wdata;
              cache_wcmd  <= 1'b1;
              mem_req     <= 1'b1;
              mem_we      <= 1'b1;
              mem_addr    <= cpu_addr;
              mem_wdata   <= cpu_wdata;
            end
          end
        end
        ST_LOOKUP: begin
          if (cache_hit) begin
            cpu_rdata <= cache_rdata;
            cpu_done  <= 1'b1;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_addr;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            r_data      <= mem_rdata;
            mem_req     <= 1'b0;
            cache_wdata <= mem_rdata;
            cache_wcmd  <= 1'b1;
          end
        end
        ST_FILL: begin
          cpu_rdata <= r_data;
          cpu_done  <= 1'b1;
        end
        ST_MEM_WR: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.CW(CW)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Self-checking bench for cache_ctrl with cache/memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0]   cpu_addr = '0, cpu_wdata = '0;
  logic [15:0]   cpu_rdata;
  logic          cpu_done;
  logic [15:0]   cache_addr, cache_wdata;
  logic          cache_wcmd;
  logic [15:0]   cache_rdata = '0;
  logic          cache_hit = 1'b0;
  logic          mem_req, mem_we;
  logic [15:0]   mem_addr, mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic          mem_ack;
  logic          mem_ack_model = 1'b0, late_ack = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;

  assign mem_ack = mem_ack_model | late_ack;

  always #5 clk = ~clk;

  cache_ctrl #(.AW(16), .DW(16), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wcmd(cache_wcmd),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] make_addr(input logic [7:0] tag, input logic [7:0] idx);
    logic [15:0] a;
    a = '0;
    a[c_TAG_MSB:c_TAG_LSB] = tag;
    a[c_IDX_MSB:c_IDX_LSB] = idx;
    return a;
  endfunction

  // Cache model: presents hit/data for the address the controller registered
  // at the previous edge; contents change only through cache_wcmd.
  logic [15:0] cache_arr [logic [15:0]];
  always @(posedge clk) begin
    #1;
    if ((^cache_addr) === 1'bx) begin
      cache_hit = 1'b0;
    end else begin
      cache_hit   = (cache_arr.exists(cache_addr) != 0);
      cache_rdata = cache_hit ? cache_arr[cache_addr] : 16'hDEAD;
    end
  end
  always @(negedge clk) begin
    if (cache_wcmd === 1'b1) cache_arr[cache_addr] = cache_wdata;
  end

  // Memory model: acks in the mem_lat-th cycle of a held request.
  logic [15:0] mem_arr [logic [15:0]];
  int mem_lat = 3;
  int mem_cnt = 0;
  always @(negedge clk) begin
    mem_ack_model = 1'b0;
    if (mem_req === 1'b1) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        mem_ack_model = 1'b1;
        mem_cnt = 0;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_init(mem_addr);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Reference model: what the cache and memory should hold, and the counters.
  logic [15:0] exp_cache [logic [15:0]];
  logic [15:0] exp_mem   [logic [15:0]];
  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] d, input int lat);
    logic        hit;
    logic [15:0] exp_rd;
    int cyc = 0, wcmds = 0, reqs = 0;
    logic done = 1'b0;
    exp_rd = '0;
    hit = we ? 1'b0 : (exp_cache.exists(a) != 0);
    if (we) begin
      exp_mem[a]   = d;
      exp_cache[a] = d;
    end else if (hit) begin
      exp_rd  = exp_cache[a];
      exp_hit = (exp_hit < SAT) ? exp_hit + 1 : SAT;
    end else begin
      exp_rd       = exp_mem.exists(a) ? exp_mem[a] : mem_init(a);
      exp_cache[a] = exp_rd;
      exp_miss     = (exp_miss < SAT) ? exp_miss + 1 : SAT;
    end
    @(negedge clk); #1;
    mem_lat = lat;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    while (!done && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (cache_wcmd) begin
        wcmds++;
        check("wcmd_addr", cache_addr, a);
        check("wcmd_data", cache_wdata, we ? d : exp_rd);
      end
      if (mem_req) begin
        reqs++;
        if (mem_ack) begin
          check("mem_addr", mem_addr, a);
          check("mem_we", mem_we, we);
          if (we) check("mem_wdata", mem_wdata, d);
        end
      end
      if (cpu_done) done = 1'b1;
    end
    cpu_req = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", cyc, we ? lat + 1 : (hit ? 2 : lat + 3));
    check("wcmd_count", wcmds, hit ? 0 : 1);
    check("mem_req_cycles", reqs, hit ? 0 : lat);
    if (!we) check("rdata", cpu_rdata, exp_rd);
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
  endtask

  logic [15:0] pool [8];

  initial begin
    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cpu_done", cpu_done, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_wdata", cache_wdata, 0);
    check("rst_cache_wcmd", cache_wcmd, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;

    cache_arr[16'h1234] = 16'hBEEF;
    exp_cache[16'h1234] = 16'hBEEF;
    do_access(1'b0, 16'h1234, 16'h0000, 1);

    mem_arr[16'h5678] = 16'hCAFE;
    exp_mem[16'h5678] = 16'hCAFE;
    do_access(1'b0, 16'h5678, 16'h0000, 5);

    do_access(1'b1, 16'h0102, 16'h1111, int'($urandom_range(1, 6)));

    // Reset two cycles into a refill wait
    @(negedge clk); #1;
    mem_lat = 50;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h7A00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (mem_req) break;
    end
    check("rst_test_mem_req_up", mem_req, 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_cpu_done", cpu_done, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    exp_hit = 0; exp_miss = 0;
    late_ack = 1'b1;
    @(negedge clk); #1;
    late_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("late_ack_done", cpu_done, 0);
      check("late_ack_wcmd", cache_wcmd, 0);
      check("late_ack_req", mem_req, 0);
    end
    do_access(1'b0, 16'h7A00, 16'h0000, 3);

    // Fresh addresses always miss and drive the miss counter into saturation
    for (int i = 0; i < 20; i++)
      do_access(1'b0, make_addr(8'h90, 8'(i)), 16'h0000, int'($urandom_range(1, 3)));
    check("miss_sat", miss_cnt, SAT);

    for (int i = 0; i < 8; i++) pool[i] = make_addr(8'hA0 + 8'(i), 8'($urandom_range(0, 255)));
    pool[0] = 16'h1234;
    pool[1] = 16'h5678;
    for (int i = 0; i < 60; i++) begin
      do_access(($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)],
                16'($urandom), int'($urandom_range(1, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
